game_state_ctl: RTL and testbench
=================================

// Module: game_state_ctl
// PURPOSE
//  Top-level game sequencer between vga_timing/draw_background and hp_control.
//  Owns MENU/GAME/GAME_OVER state and drives game_on (background + mouse_constrainer mode).
//  Gates player hits through an invulnerability window before forwarding them to hp_control.
//  Schedules obstacle attacks frame-by-frame: selects the active attack and pulses its start.
// PARAMETERS
//  N_ATTACKS       4    number of attack patterns; must equal 2**ATK_W
//  ATK_W           2    width of attack_sel
//  ATTACK_FRAMES   600  frames per attack before forced advance (10 s @ 60 Hz)
//  INVULN_FRAMES   60   frames of hit immunity after a forwarded hit
//  GAMEOVER_FRAMES 180  frames in GAME_OVER before automatic return to MENU
// PORTS
//  pclk           in   1      pixel clock (65 MHz); single clock domain
//  rst            in   1      synchronous, active-high reset
//  vsync_in       in   1      vsync from vga_timing; rising edge = frame tick
//  game_btn       in   1      start-game level (pre-synchronised)
//  menu_btn       in   1      return-to-menu level (pre-synchronised)
//  player_hit     in   1      one-cycle hit pulse from collision logic
//  hp_empty       in   1      game_over level from hp_control
//  attack_done    in   1      one-cycle pulse: active attack finished early
//  game_on        out  1      1 in GAME
//  menu_on        out  1      1 in MENU
//  game_over_flag out  1      1 in GAME_OVER
//  hit_out        out  1      one-cycle forwarded hit to hp_control
//  invuln         out  1      1 while immunity counter is nonzero
//  attack_sel     out  ATK_W  index of active attack
//  attack_start   out  1      one-cycle pulse when attack_sel becomes valid
//  state_out      out  2      00 MENU, 01 GAME, 10 GAME_OVER
// BEHAVIOUR
//  Reset: state MENU; menu_on=1; every other output 0; attack_sel=0; counters 0.
//   Edge-detect regs: vsync_d reset 0; game_btn_d/menu_btn_d reset 1 (button held through reset never fires).
//  All outputs registered; 1-cycle latency from the triggering input/edge to the output.
//  frame_tick = vsync_in & ~vsync_d. Button events = rising edges only; a held button fires once.
//  MENU: game_btn edge -> GAME. On entry: attack_sel=0, frame_cnt=0, invuln cnt=0, attack_start=1 for one cycle.
//   player_hit, hp_empty, attack_done ignored.
//  GAME, priority per cycle, highest first:
//   1 hp_empty=1 -> GAME_OVER; the same-cycle hit and advance are dropped.
//   2 menu_btn edge -> MENU.
//   3 Attack advance: on attack_done, or on frame_tick with frame_cnt==ATTACK_FRAMES-1:
//     attack_sel <= next; frame_cnt <= 0; attack_start pulses.
//     Both in the same cycle -> exactly one advance.
//   4 Otherwise frame_tick increments frame_cnt.
//   Hits (evaluated in parallel with 3/4):
//   - player_hit with inv_cnt==0 -> hit_out=1 next cycle; inv_cnt <= INVULN_FRAMES.
//   - player_hit with inv_cnt!=0 -> dropped.
//   - inv_cnt decrements on frame_tick, saturating at 0.
//  GAME_OVER: on entry go_cnt=0; go_cnt increments per frame_tick.
//   go_cnt==GAMEOVER_FRAMES-1 on a tick -> MENU. menu_btn edge -> MENU immediately.
//   game_btn ignored. hit_out=0, attack_start=0.
//  Any transition out of GAME clears inv_cnt and frame_cnt.
//  rst mid-game -> full reset state on the next edge; no hit_out is emitted.
// CONFIGURATION
//  ATTACK_RANDOM_EN defined:
//   - 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, steps every pclk.
//   - next = lfsr[ATK_W-1:0]; if next==attack_sel, use attack_sel+1 (mod N_ATTACKS).
//   - First attack after MENU is still 0.
//  ATTACK_RANDOM_EN undefined: next = attack_sel+1 (mod N_ATTACKS), round robin 0,1,2,3,0...
// TESTING
//  1 rst, then game_btn pulse -> state_out=01, game_on=1, attack_sel=0, attack_start one pulse.
//  2 ATTACK_FRAMES=4, N_ATTACKS=4, round robin; 17 frame ticks -> attack_sel 0,1,2,3,0; 5 attack_start pulses.
//  3 INVULN_FRAMES=2: hit at t0 -> hit_out; hit after 1 tick -> none; hit after 2 more ticks -> hit_out.
//  4 hp_empty with player_hit in the same cycle -> GAME_OVER, no hit_out.
//    GAMEOVER_FRAMES=3 -> MENU after 3 ticks; held game_btn in GAME_OVER ignored.
//  5 attack_done coincident with timer expiry -> single advance.
//    Button held through rst -> no start; menu_btn edge in GAME -> MENU.
//  6 ATTACK_RANDOM_EN: 64 advances -> attack_sel never repeats consecutively; seed reproducible after rst.

Source files
------------

// File: rtl/game_state_ctl.sv
// Game sequencer: MENU/GAME/GAME_OVER control, hit gating through an invulnerability
// window, and frame-based attack scheduling. Define ATTACK_RANDOM_EN for LFSR attack order.
module game_state_ctl #(
  parameter int N_ATTACKS       = 4,
  parameter int ATK_W           = 2,
  parameter int ATTACK_FRAMES   = 600,
  parameter int INVULN_FRAMES   = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             game_btn,
  input  logic             menu_btn,
  input  logic             player_hit,
  input  logic             hp_empty,
  input  logic             attack_done,
  output logic             game_on,
  output logic             menu_on,
  output logic             game_over_flag,
  output logic             hit_out,
  output logic             invuln,
  output logic [ATK_W-1:0] attack_sel,
  output logic             attack_start,
  output logic [1:0]       state_out
);

  localparam int FC_W = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
  localparam int IV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int GO_W = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;

  localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(ATTACK_FRAMES - 1);
  localparam logic [IV_W-1:0]  INV_LOAD   = IV_W'(INVULN_FRAMES);
  localparam logic [GO_W-1:0]  GO_LAST    = GO_W'(GAMEOVER_FRAMES - 1);
  localparam logic [ATK_W-1:0] ATK_LAST   = ATK_W'(N_ATTACKS - 1);

  typedef enum logic [1:0] {
    S_MENU = 2'b00,
    S_GAME = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             vsync_q, game_btn_q, menu_btn_q;
  logic [ATK_W-1:0] attack_sel_q, attack_sel_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [IV_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [GO_W-1:0]  go_cnt_q, go_cnt_d;
  logic             hit_out_q, hit_out_d;
  logic             attack_start_q, attack_start_d;

  logic             frame_tick, game_edge, menu_edge;
  logic             advance;
  logic [ATK_W-1:0] sel_inc, next_sel;

  // Button regs reset high so a button already held when reset releases never fires.
  assign frame_tick = vsync_in & ~vsync_q;
  assign game_edge  = game_btn & ~game_btn_q;
  assign menu_edge  = menu_btn & ~menu_btn_q;

  assign sel_inc = (attack_sel_q == ATK_LAST) ? '0 : attack_sel_q + ATK_W'(1);

`ifdef ATTACK_RANDOM_EN
  logic [7:0]       lfsr_q;
  logic             lfsr_fb;
  logic [ATK_W-1:0] rand_sel;

  // x^8 + x^6 + x^5 + x^4 + 1, free-running so the pick depends on when the advance lands.
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign rand_sel = lfsr_q[ATK_W-1:0];
  assign next_sel = (rand_sel == attack_sel_q) ? sel_inc : rand_sel;

  always_ff @(posedge pclk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
`else
  assign next_sel = sel_inc;
`endif

  assign advance = attack_done | (frame_tick & (frame_cnt_q == FRAME_LAST));

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= S_MENU;
      vsync_q        <= 1'b0;
      game_btn_q     <= 1'b1;
      menu_btn_q     <= 1'b1;
      attack_sel_q   <= '0;
      frame_cnt_q    <= '0;
      inv_cnt_q      <= '0;
      go_cnt_q       <= '0;
      hit_out_q      <= 1'b0;
      attack_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync_in;
      game_btn_q     <= game_btn;
      menu_btn_q     <= menu_btn;
      attack_sel_q   <= attack_sel_d;
      frame_cnt_q    <= frame_cnt_d;
      inv_cnt_q      <= inv_cnt_d;
      go_cnt_q       <= go_cnt_d;
      hit_out_q      <= hit_out_d;
      attack_start_q <= attack_start_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    attack_sel_d   = attack_sel_q;
    frame_cnt_d    = frame_cnt_q;
    inv_cnt_d      = inv_cnt_q;
    go_cnt_d       = go_cnt_q;
    hit_out_d      = 1'b0;
    attack_start_d = 1'b0;

    unique case (state_q)
      S_MENU: begin
        if (game_edge) begin
          state_d        = S_GAME;
          attack_sel_d   = '0;
          frame_cnt_d    = '0;
          inv_cnt_d      = '0;
          attack_start_d = 1'b1;
        end
      end

      S_GAME: begin
        if (hp_empty) begin
          state_d     = S_OVER;
          frame_cnt_d = '0;
          inv_cnt_d   = '0;
          go_cnt_d    = '0;
        end else if (menu_edge) begin
          state_d     = S_MENU;
          frame_cnt_d = '0;
          inv_cnt_d   = '0;
        end else begin
          if (advance) begin
            attack_sel_d   = next_sel;
            frame_cnt_d    = '0;
            attack_start_d = 1'b1;
          end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
          // A hit that reloads the window wins over a same-cycle decrement.
          if (player_hit && (inv_cnt_q == '0)) begin
            hit_out_d = 1'b1;
            inv_cnt_d = INV_LOAD;
          end else if (frame_tick && (inv_cnt_q != '0)) begin
            inv_cnt_d = inv_cnt_q - IV_W'(1);
          end
        end
      end

      S_OVER: begin
        if (menu_edge) begin
          state_d = S_MENU;
        end else if (frame_tick) begin
          if (go_cnt_q == GO_LAST) state_d = S_MENU;
          else                     go_cnt_d = go_cnt_q + GO_W'(1);
        end
      end

      default: state_d = S_MENU;
    endcase
  end

  assign game_on        = (state_q == S_GAME);
  assign menu_on        = (state_q == S_MENU);
  assign game_over_flag = (state_q == S_OVER);
  assign hit_out        = hit_out_q;
  assign invuln         = (inv_cnt_q != '0);
  assign attack_sel     = attack_sel_q;
  assign attack_start   = attack_start_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for game_state_ctl with short frame parameters; ATTACK_RANDOM_EN
// selects the LFSR-order scenario instead of the round-robin ones.
module tb_game_state_ctl;

  localparam int ATK_W = 2;

  logic             pclk = 1'b0;
  logic             rst = 1'b1;
  logic             vsync_in = 1'b0;
  logic             game_btn = 1'b0;
  logic             menu_btn = 1'b0;
  logic             player_hit = 1'b0;
  logic             hp_empty = 1'b0;
  logic             attack_done = 1'b0;
  logic             game_on, menu_on, game_over_flag, hit_out, invuln, attack_start;
  logic [ATK_W-1:0] attack_sel;
  logic [1:0]       state_out;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int hit_cnt = 0;
  logic [ATK_W-1:0] sel_log[$];
  logic [ATK_W-1:0] exp_q[$];

  game_state_ctl #(
    .N_ATTACKS(4), .ATK_W(ATK_W), .ATTACK_FRAMES(4),
    .INVULN_FRAMES(2), .GAMEOVER_FRAMES(3)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .game_btn(game_btn),
    .menu_btn(menu_btn), .player_hit(player_hit), .hp_empty(hp_empty),
    .attack_done(attack_done), .game_on(game_on), .menu_on(menu_on),
    .game_over_flag(game_over_flag), .hit_out(hit_out), .invuln(invuln),
    .attack_sel(attack_sel), .attack_start(attack_start), .state_out(state_out)
  );

  always #5 pclk = ~pclk;

  // Pulse monitor on the falling edge, away from the register updates.
  always @(negedge pclk) begin
    if (attack_start) begin
      start_cnt = start_cnt + 1;
      sel_log.push_back(attack_sel);
    end
    if (hit_out) hit_cnt = hit_cnt + 1;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync_in = 1'b0; player_hit = 1'b0; hp_empty = 1'b0; attack_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic enter_game();
    game_btn = 1'b1;
    step();
    game_btn = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_out !== 2'b00 || menu_on !== 1'b1 || game_on !== 1'b0 || game_over_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got state=%b menu=%b game=%b over=%b exp 00 1 0 0",
               state_out, menu_on, game_on, game_over_flag);
    end
    checks++;
    if (hit_out !== 1'b0 || invuln !== 1'b0 || attack_sel !== 2'd0 || attack_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got hit=%b inv=%b sel=%0d start=%b exp 0 0 0 0",
               hit_out, invuln, attack_sel, attack_start);
    end
  endtask

  task automatic test_start();
    game_btn = 1'b1;
    step();
    checks++;
    if (state_out !== 2'b01 || game_on !== 1'b1 || menu_on !== 1'b0) begin
      errors++;
      $display("FAIL start_state got state=%b game=%b menu=%b exp 01 1 0", state_out, game_on, menu_on);
    end
    checks++;
    if (attack_sel !== 2'd0 || attack_start !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse got sel=%0d start=%b exp 0 1", attack_sel, attack_start);
    end
    step();
    checks++;
    if (attack_start !== 1'b0) begin
      errors++;
      $display("FAIL start_one_cycle got start=%b exp 0", attack_start);
    end
    game_btn = 1'b0;
    step();
  endtask

  task automatic test_menu_exit();
    menu_btn = 1'b1;
    step();
    checks++;
    if (state_out !== 2'b00 || menu_on !== 1'b1 || game_on !== 1'b0) begin
      errors++;
      $display("FAIL menu_exit got state=%b menu=%b game=%b exp 00 1 0", state_out, menu_on, game_on);
    end
    step();
    menu_btn = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int n0;
    int s0;
    do_reset();
    n0 = sel_log.size();
    s0 = start_cnt;
    enter_game();
    for (int i = 0; i < 17; i++) tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    checks++;
    if (start_cnt - s0 != 5) begin
      errors++;
      $display("FAIL rr_pulse_count got %0d exp 5", start_cnt - s0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (n0 + i >= sel_log.size()) begin
        errors++;
        $display("FAIL rr_seq[%0d] got none exp %0d", i, exp_q[i]);
      end else if (sel_log[n0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d] got %0d exp %0d", i, sel_log[n0 + i], exp_q[i]);
      end
    end
    checks++;
    if (attack_sel !== 2'd0) begin
      errors++;
      $display("FAIL rr_final_sel got %0d exp 0", attack_sel);
    end
  endtask

  task automatic test_invuln();
    int h0;
    h0 = hit_cnt;
    player_hit = 1'b1; step(); player_hit = 1'b0;
    checks++;
    if (hit_out !== 1'b1 || invuln !== 1'b1) begin
      errors++;
      $display("FAIL inv_first_hit got hit=%b inv=%b exp 1 1", hit_out, invuln);
    end
    step();
    checks++;
    if (hit_out !== 1'b0) begin
      errors++;
      $display("FAIL inv_hit_one_cycle got %b exp 0", hit_out);
    end
    tick();
    checks++;
    if (invuln !== 1'b1) begin
      errors++;
      $display("FAIL inv_after_1_tick got %b exp 1", invuln);
    end
    player_hit = 1'b1; step(); player_hit = 1'b0;
    checks++;
    if (hit_out !== 1'b0) begin
      errors++;
      $display("FAIL inv_dropped_hit got %b exp 0", hit_out);
    end
    tick();
    tick();
    checks++;
    if (invuln !== 1'b0) begin
      errors++;
      $display("FAIL inv_expired got %b exp 0", invuln);
    end
    player_hit = 1'b1; step(); player_hit = 1'b0;
    checks++;
    if (hit_out !== 1'b1) begin
      errors++;
      $display("FAIL inv_second_hit got %b exp 1", hit_out);
    end
    step();
    checks++;
    if (hit_cnt - h0 != 2) begin
      errors++;
      $display("FAIL inv_hit_count got %0d exp 2", hit_cnt - h0);
    end
  endtask

  task automatic test_hp_empty();
    int h0;
    h0 = hit_cnt;
    player_hit = 1'b1; hp_empty = 1'b1;
    step();
    player_hit = 1'b0; hp_empty = 1'b0;
    checks++;
    if (state_out !== 2'b10 || game_over_flag !== 1'b1 || game_on !== 1'b0) begin
      errors++;
      $display("FAIL over_entry got state=%b over=%b game=%b exp 10 1 0", state_out, game_over_flag, game_on);
    end
    checks++;
    if (hit_out !== 1'b0 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL over_no_hit got hit=%b inv=%b exp 0 0", hit_out, invuln);
    end
    game_btn = 1'b1;
    step();
    tick();
    tick();
    checks++;
    if (state_out !== 2'b10) begin
      errors++;
      $display("FAIL over_hold got state=%b exp 10", state_out);
    end
    tick();
    checks++;
    if (state_out !== 2'b00 || menu_on !== 1'b1) begin
      errors++;
      $display("FAIL over_timeout got state=%b menu=%b exp 00 1", state_out, menu_on);
    end
    step(); step(); step();
    checks++;
    if (state_out !== 2'b00) begin
      errors++;
      $display("FAIL held_btn_in_menu got state=%b exp 00", state_out);
    end
    game_btn = 1'b0;
    step();
    checks++;
    if (hit_cnt != h0) begin
      errors++;
      $display("FAIL over_hit_count got %0d exp %0d", hit_cnt, h0);
    end
  endtask

  task automatic test_coincident();
    int s0;
    do_reset();
    enter_game();
    s0 = start_cnt;
    tick(); tick(); tick();
    vsync_in = 1'b1; attack_done = 1'b1;
    step();
    vsync_in = 1'b0; attack_done = 1'b0;
    checks++;
    if (attack_sel !== 2'd1 || attack_start !== 1'b1) begin
      errors++;
      $display("FAIL coinc_advance got sel=%0d start=%b exp 1 1", attack_sel, attack_start);
    end
    step();
    checks++;
    if (attack_sel !== 2'd1 || attack_start !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL coinc_single got sel=%0d start=%b pulses=%0d exp 1 0 1",
               attack_sel, attack_start, start_cnt - s0);
    end
    tick(); tick(); tick();
    checks++;
    if (attack_sel !== 2'd1) begin
      errors++;
      $display("FAIL coinc_frame_reset got sel=%0d exp 1", attack_sel);
    end
    tick();
    checks++;
    if (attack_sel !== 2'd2) begin
      errors++;
      $display("FAIL coinc_next_timer got sel=%0d exp 2", attack_sel);
    end
    attack_done = 1'b1; step(); attack_done = 1'b0;
    checks++;
    if (attack_sel !== 2'd3 || attack_start !== 1'b1) begin
      errors++;
      $display("FAIL early_done got sel=%0d start=%b exp 3 1", attack_sel, attack_start);
    end
    step();
  endtask

  task automatic test_btn_through_reset();
    int s0;
    s0 = start_cnt;
    game_btn = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if (state_out !== 2'b00 || start_cnt != s0) begin
      errors++;
      $display("FAIL held_through_rst got state=%b pulses=%0d exp 00 0", state_out, start_cnt - s0);
    end
    game_btn = 1'b0;
    step();
    game_btn = 1'b1;
    step();
    checks++;
    if (state_out !== 2'b01) begin
      errors++;
      $display("FAIL restart_after_release got state=%b exp 01", state_out);
    end
    game_btn = 1'b0;
    step();
  endtask

  task automatic test_rst_mid_game();
    int h0;
    enter_game();
    h0 = hit_cnt;
    player_hit = 1'b1; rst = 1'b1;
    step();
    player_hit = 1'b0; rst = 1'b0;
    checks++;
    if (hit_out !== 1'b0 || state_out !== 2'b00 || attack_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_game got hit=%b state=%b sel=%0d exp 0 00 0", hit_out, state_out, attack_sel);
    end
    step();
    checks++;
    if (hit_cnt != h0) begin
      errors++;
      $display("FAIL rst_mid_hit_count got %0d exp %0d", hit_cnt, h0);
    end
  endtask

`ifdef ATTACK_RANDOM_EN
  task automatic test_random();
    logic [ATK_W-1:0] seq1[64];
    logic [ATK_W-1:0] prev;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      enter_game();
      checks++;
      if (attack_sel !== 2'd0) begin
        errors++;
        $display("FAIL rand_first got %0d exp 0", attack_sel);
      end
      for (int i = 0; i < 64; i++) begin
        prev = attack_sel;
        attack_done = 1'b1; step(); attack_done = 1'b0;
        checks++;
        if (attack_sel === prev) begin
          errors++;
          $display("FAIL rand_repeat[%0d] got %0d prev %0d", i, attack_sel, prev);
        end
        if (pass == 0) begin
          seq1[i] = attack_sel;
        end else begin
          checks++;
          if (attack_sel !== seq1[i]) begin
            errors++;
            $display("FAIL rand_reproduce[%0d] got %0d exp %0d", i, attack_sel, seq1[i]);
          end
        end
        step();
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_menu_exit();
`ifdef ATTACK_RANDOM_EN
    test_random();
    do_reset();
    enter_game();
`else
    test_round_robin();
`endif
    test_invuln();
    test_hp_empty();
`ifndef ATTACK_RANDOM_EN
    test_coincident();
`endif
    test_btn_through_reset();
    test_menu_exit();
    test_rst_mid_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
